// File: rtl/npu_pkg.sv
// npu_pkg: shared NPU sizes, arbiter state encoding and a saturating counter helper
package npu_pkg;
    localparam int NPU_NUM_MAC    = 32;
    localparam int NPU_ACT_ADDR_W = 12;
    localparam int NPU_ACT_DATA_W = 8;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} arb_state_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction
endpackage

// File: rtl/npu_rr_pick.sv
// npu_rr_pick: combinational round-robin search, first set req bit at or after ptr (wrapping)
module npu_rr_pick #(
    parameter int NUM_REQ = 32,
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic               valid,
    output logic [IW-1:0]      idx
);
    logic [IW-1:0] lane;

    // Walk offsets from farthest to nearest so the lane closest to ptr wins last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        lane  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            lane = IW'((int'(ptr) + i) % NUM_REQ);
            if (req[lane]) begin
                valid = 1'b1;
                idx   = lane;
            end
        end
    end
endmodule

// File: rtl/npu_act_wr_arbiter.sv
// npu_act_wr_arbiter: round-robin arbiter funnelling MAC-lane writes into the activation memory.
// Optional statistics counters are enabled by defining NPU_ACT_WR_ARB_STATS_EN.
module npu_act_wr_arbiter
    import npu_pkg::*;
#(
    parameter int NUM_REQ = NPU_NUM_MAC,
    parameter int ADDR_W  = NPU_ACT_ADDR_W,
    parameter int DATA_W  = NPU_ACT_DATA_W
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [NUM_REQ-1:0]          hw_mem_wr,
    input  logic [NUM_REQ*ADDR_W-1:0]   hw_mem_wr_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   hw_mem_wr_data,
    output logic [NUM_REQ-1:0]          hw_mem_wr_ack_p,
    output logic                        npu_act_mem_wr_en,
    output logic [ADDR_W-1:0]           npu_act_mem_wr_addr,
    output logic [DATA_W-1:0]           npu_act_mem_wr_data,
    input  logic                        layer_done_p,
    output logic                        drain_done_p,
    output logic                        arb_busy,
    output logic [15:0]                 wr_count,
    output logic [15:0]                 stall_count
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e         state, state_nx;
    logic [IW-1:0]      rr_ptr, pick_idx;
    logic               pick_valid, req_any, quiet, drain_exit;
    logic [NUM_REQ-1:0] elig, grant_oh;

    // A lane whose ack is visible this cycle is still holding its request; skip it.
    assign elig     = hw_mem_wr & ~hw_mem_wr_ack_p;
    assign req_any  = |hw_mem_wr;
    assign quiet    = !req_any && !npu_act_mem_wr_en;
    assign grant_oh = pick_valid ? (NUM_REQ'(1) << pick_idx) : '0;
    assign arb_busy = state != IDLE;

    npu_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (elig),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_nx   = state;
        drain_exit = 1'b0;
        case (state)
            IDLE:    state_nx = layer_done_p ? DRAIN : (req_any ? RUN : IDLE);
            RUN:     state_nx = layer_done_p ? DRAIN : (quiet ? IDLE : RUN);
            DRAIN: begin
                drain_exit = quiet;
                state_nx   = quiet ? IDLE : DRAIN;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state               <= IDLE;
            rr_ptr              <= '0;
            npu_act_mem_wr_en   <= 1'b0;
            npu_act_mem_wr_addr <= '0;
            npu_act_mem_wr_data <= '0;
            hw_mem_wr_ack_p     <= '0;
            drain_done_p        <= 1'b0;
        end else begin
            state             <= state_nx;
            drain_done_p      <= drain_exit;
            npu_act_mem_wr_en <= pick_valid;
            hw_mem_wr_ack_p   <= grant_oh;
            if (pick_valid) begin
                rr_ptr              <= (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                npu_act_mem_wr_addr <= hw_mem_wr_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                npu_act_mem_wr_data <= hw_mem_wr_data[int'(pick_idx)*DATA_W +: DATA_W];
            end
        end
    end

`ifdef NPU_ACT_WR_ARB_STATS_EN
    logic stall;
    assign stall = |(elig & ~grant_oh);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_count    <= '0;
            stall_count <= '0;
        end else if (drain_exit) begin
            wr_count    <= '0;
            stall_count <= '0;
        end else begin
            wr_count    <= sat_inc(wr_count, npu_act_mem_wr_en);
            stall_count <= sat_inc(stall_count, stall);
        end
    end
`else
    assign wr_count    = '0;
    assign stall_count = '0;
`endif
endmodule

// File: tb/tb_npu_act_wr_arbiter.sv
// tb_npu_act_wr_arbiter: randomized scoreboard bench for the activation write arbiter
module tb_npu_act_wr_arbiter;
    localparam int N  = 32;
    localparam int AW = 12;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            resetn;
    logic [N-1:0]    req;
    logic [N*AW-1:0] hw_mem_wr_addr;
    logic [N*DW-1:0] hw_mem_wr_data;
    logic [N-1:0]    hw_mem_wr_ack_p;
    logic            npu_act_mem_wr_en;
    logic [AW-1:0]   npu_act_mem_wr_addr;
    logic [DW-1:0]   npu_act_mem_wr_data;
    logic            layer_done_p;
    logic            drain_done_p;
    logic            arb_busy;
    logic [15:0]     wr_count, stall_count;

    logic [AW-1:0] la[N];
    logic [DW-1:0] ldat[N];
    bit            hold[N];

    always #5 clk = ~clk;

    always_comb begin
        hw_mem_wr_addr = '0;
        hw_mem_wr_data = '0;
        for (int i = 0; i < N; i++) begin
            hw_mem_wr_addr[i*AW +: AW] = la[i];
            hw_mem_wr_data[i*DW +: DW] = ldat[i];
        end
    end

    npu_act_wr_arbiter dut (
        .clk                 (clk),
        .resetn              (resetn),
        .hw_mem_wr           (req),
        .hw_mem_wr_addr      (hw_mem_wr_addr),
        .hw_mem_wr_data      (hw_mem_wr_data),
        .hw_mem_wr_ack_p     (hw_mem_wr_ack_p),
        .npu_act_mem_wr_en   (npu_act_mem_wr_en),
        .npu_act_mem_wr_addr (npu_act_mem_wr_addr),
        .npu_act_mem_wr_data (npu_act_mem_wr_data),
        .layer_done_p        (layer_done_p),
        .drain_done_p        (drain_done_p),
        .arb_busy            (arb_busy),
        .wr_count            (wr_count),
        .stall_count         (stall_count)
    );

    typedef struct {int lane; logic [AW-1:0] addr; logic [DW-1:0] data;} wr_t;
    typedef struct {bit wr; bit busy; bit drain; int wc; int sc;} ctl_t;
    wr_t  wr_q[$];
    ctl_t ctl_q[$];

    int checks = 0, failures = 0;
    // Reference model: round-robin pointer, lane acked last cycle, phase 0=idle 1=run 2=drain
    int m_ptr, m_last, m_st, m_wc, m_sc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_last = -1; m_st = 0; m_wc = 0; m_sc = 0;
        wr_q.delete();
        ctl_q.delete();
    endtask

    // Predict the outcome of the next rising edge from current inputs, then advance one cycle.
    task automatic tick();
        logic [N-1:0] elig;
        int  g, n;
        bit  any, wr_cur, ex;
        elig = req;
        if (m_last >= 0) elig[m_last] = 1'b0;
        g = -1;
        for (int k = 0; k < N; k++) begin
            int l;
            l = (m_ptr + k) % N;
            if (g < 0 && elig[l]) g = l;
        end
        n = $countones(elig);
        any = |req;
        wr_cur = m_last >= 0;
        ex = 0;
        if (m_st == 2) begin
            if (!any && !wr_cur) begin m_st = 0; ex = 1; end
        end else if (layer_done_p) m_st = 2;
        else if (m_st == 0) begin
            if (any) m_st = 1;
        end else if (!any && !wr_cur) m_st = 0;
        if (ex) begin
            m_wc = 0; m_sc = 0;
        end else begin
            if (wr_cur && m_wc < 65535) m_wc++;
            if (n > 1 && m_sc < 65535) m_sc++;
        end
        ctl_q.push_back('{g >= 0, m_st != 0, ex, m_wc, m_sc});
        if (g >= 0) begin
            wr_q.push_back('{g, la[g], ldat[g]});
            m_ptr = (g + 1) % N;
        end
        m_last = g;
        @(negedge clk);
        #1;
    endtask

    task automatic new_req(input int i, input bit h);
        req[i]  = 1'b1;
        la[i]   = AW'($urandom);
        ldat[i] = DW'($urandom);
        hold[i] = h;
    endtask

    // Acked lanes drop (or, if holding, may keep requesting with fresh data); idle lanes may start.
    task automatic update_reqs(input int p_new);
        for (int i = 0; i < N; i++) begin
            if (req[i] && m_last == i) begin
                if (!hold[i] || $urandom_range(2) == 0) req[i] = 1'b0;
                else new_req(i, 1'b1);
            end else if (!req[i] && $urandom_range(99) < p_new)
                new_req(i, $urandom_range(7) == 0);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        chk("rst_wr_en", 64'(npu_act_mem_wr_en), 64'd0);
        chk("rst_ack", 64'(hw_mem_wr_ack_p), 64'd0);
        chk("rst_busy", 64'(arb_busy), 64'd0);
        chk("rst_drain", 64'(drain_done_p), 64'd0);
        model_reset();
        req = '0;
        @(negedge clk);
        #1;
        resetn = 1'b1;
    endtask

    ctl_t mc;
    wr_t  mw;
    always @(negedge clk) begin
        if (resetn === 1'b1 && ctl_q.size() > 0) begin
            mc = ctl_q.pop_front();
            chk("wr_en", 64'(npu_act_mem_wr_en), 64'(mc.wr));
            chk("arb_busy", 64'(arb_busy), 64'(mc.busy));
            chk("drain_done_p", 64'(drain_done_p), 64'(mc.drain));
`ifdef NPU_ACT_WR_ARB_STATS_EN
            chk("wr_count", 64'(wr_count), 64'(mc.wc));
            chk("stall_count", 64'(stall_count), 64'(mc.sc));
`else
            chk("wr_count", 64'(wr_count), 64'd0);
            chk("stall_count", 64'(stall_count), 64'd0);
`endif
            if (mc.wr && wr_q.size() > 0) begin
                mw = wr_q.pop_front();
                chk("wr_addr", 64'(npu_act_mem_wr_addr), 64'(mw.addr));
                chk("wr_data", 64'(npu_act_mem_wr_data), 64'(mw.data));
                chk("ack_p", 64'(hw_mem_wr_ack_p), 64'(N'(1) << mw.lane));
            end else
                chk("ack_idle", 64'(hw_mem_wr_ack_p), 64'd0);
        end
    end

    int order[6] = '{0, 1, 31, 0, 1, 31};
    int writes, drains;

    initial begin
        resetn = 1'b0;
        req = '0;
        layer_done_p = 1'b0;
        for (int i = 0; i < N; i++) begin la[i] = '0; ldat[i] = '0; hold[i] = 0; end
        model_reset();
        #2;
        chk("init_wr_en", 64'(npu_act_mem_wr_en), 64'd0);
        chk("init_addr", 64'(npu_act_mem_wr_addr), 64'd0);
        chk("init_data", 64'(npu_act_mem_wr_data), 64'd0);
        chk("init_ack", 64'(hw_mem_wr_ack_p), 64'd0);
        chk("init_busy", 64'(arb_busy), 64'd0);
        chk("init_cnt", 64'({wr_count, stall_count}), 64'd0);
        @(negedge clk);
        #1;
        resetn = 1'b1;

        req[5] = 1'b1; la[5] = 12'h010; ldat[5] = 8'hA5; hold[5] = 0;
        tick();
        chk("l5_wr_en", 64'(npu_act_mem_wr_en), 64'd1);
        chk("l5_addr", 64'(npu_act_mem_wr_addr), 64'h010);
        chk("l5_data", 64'(npu_act_mem_wr_data), 64'hA5);
        chk("l5_ack", 64'(hw_mem_wr_ack_p), 64'h20);
        update_reqs(0);
        repeat (3) tick();

        do_reset();
        for (int i = 0; i < N; i++) if (i == 0 || i == 1 || i == 31) new_req(i, 1'b1);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rr_order", 64'(hw_mem_wr_ack_p), 64'(N'(1) << order[k]));
        end
        req = '0;
        repeat (3) tick();

        new_req(7, 1'b1);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("single_lane_ack", 64'(hw_mem_wr_ack_p[7]), 64'(k % 2 == 0));
        end
        req = '0;
        repeat (3) tick();

        for (int k = 0; k < 10; k++) begin
            update_reqs(50);
            tick();
        end
        do_reset();
        new_req(0, 1'b0); new_req(9, 1'b0); new_req(20, 1'b0);
        tick();
        chk("post_reset_first", 64'(hw_mem_wr_ack_p), 64'd1);
        for (int k = 0; k < 10; k++) begin update_reqs(0); tick(); end

        for (int i = 0; i < N; i++) new_req(i, 1'b0);
        layer_done_p = 1'b1;
        writes = 0; drains = 0;
        tick();
        layer_done_p = 1'b0;
        for (int k = 0; k < 40; k++) begin
            writes += int'(npu_act_mem_wr_en);
            drains += int'(drain_done_p);
            update_reqs(0);
            tick();
        end
        chk("drain_writes", 64'(writes), 64'd32);
        chk("drain_pulses", 64'(drains), 64'd1);

        for (int k = 0; k < 400; k++) begin
            update_reqs(k % 100 < 50 ? 8 : 60);
            layer_done_p = $urandom_range(14) == 0;
            tick();
            layer_done_p = 1'b0;
        end
        for (int k = 0; k < 200 && req != '0; k++) begin
            update_reqs(0);
            tick();
        end
        repeat (4) tick();
        chk("wr_q_empty", 64'(wr_q.size()), 64'd0);
        chk("ctl_q_empty", 64'(ctl_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
